// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the execute-stage ALU arbiter: op codes, FSM encodings, defaults.
package alu_arbiter_pkg;

   localparam int WORD_SIZE_DEFAULT   = 32;
   localparam int MUL_LATENCY_DEFAULT = 4;

   typedef enum logic [2:0] {
      ADD_OP = 3'd0,
      SUB_OP = 3'd1,
      MUL_OP = 3'd2,
      AND_OP = 3'd3,
      OR_OP  = 3'd4
   } alu_op_e;

   typedef enum logic {
      ALU_STATE_IDLE = 1'b0,
      ALU_STATE_EXEC = 1'b1
   } alu_state_e;

   function automatic logic op_defined(input logic [2:0] op);
      return (op == ADD_OP) || (op == SUB_OP) || (op == MUL_OP) ||
             (op == AND_OP) || (op == OR_OP);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the pointer moves to the other port on accept.
// Grant is combinational from valid and enable; only the pointer is registered.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       rr_ptr
);

   logic winner;

   always_comb begin
      winner = 1'b0;
      grant  = 2'b00;
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = rr_ptr;
         default: winner = 1'b0;
      endcase
      if (enable && (req != 2'b00)) begin
         grant[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (grant != 2'b00) begin
         rr_ptr <= ~winner;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; holds operands for 1 cycle (MUL_LATENCY for MUL)
// and returns a tagged, registered result pulse. Requests wait (ready low) while busy.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEFAULT,
   parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WORD_SIZE-1:0] req0_srcA,
   input  logic [WORD_SIZE-1:0] req0_srcB,
   input  logic [2:0]           req0_op,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WORD_SIZE-1:0] req1_srcA,
   input  logic [WORD_SIZE-1:0] req1_srcB,
   input  logic [2:0]           req1_op,
   output logic [WORD_SIZE-1:0] alu_srcA,
   output logic [WORD_SIZE-1:0] alu_srcB,
   output logic [2:0]           alu_ctrl,
   input  logic [WORD_SIZE-1:0] alu_out,
   output logic                 rsp_valid,
   output logic                 rsp_id,
   output logic [WORD_SIZE-1:0] rsp_result,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);

   alu_state_e state;
   logic [3:0] cnt;
   logic       op_id;
   logic [1:0] grant;
   logic       rr_ptr;
   logic       accept;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (state == ALU_STATE_IDLE),
      .req    ({req1_valid, req0_valid}),
      .grant  (grant),
      .rr_ptr (rr_ptr)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign accept     = grant[0] | grant[1];

   // ALU-facing operands are registered so they stay frozen for the whole
   // multicycle MUL path and read as zero/ADD whenever no op is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ALU_STATE_IDLE;
         cnt        <= '0;
         op_id      <= 1'b0;
         alu_srcA   <= '0;
         alu_srcB   <= '0;
         alu_ctrl   <= ADD_OP;
         busy       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ALU_STATE_IDLE: begin
               if (accept) begin
                  alu_srcA <= grant[1] ? req1_srcA : req0_srcA;
                  alu_srcB <= grant[1] ? req1_srcB : req0_srcB;
                  alu_ctrl <= grant[1] ? req1_op   : req0_op;
                  op_id    <= grant[1];
                  cnt      <= ((grant[1] ? req1_op : req0_op) == MUL_OP) ? MUL_CNT : 4'd0;
                  busy     <= 1'b1;
                  state    <= ALU_STATE_EXEC;
               end
            end
            ALU_STATE_EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_result <= alu_out;
                  rsp_err    <= ~op_defined(alu_ctrl);
                  rsp_id     <= op_id;
                  rsp_valid  <= 1'b1;
                  alu_srcA   <= '0;
                  alu_srcB   <= '0;
                  alu_ctrl   <= ADD_OP;
                  busy       <= 1'b0;
                  state      <= ALU_STATE_IDLE;
               end
            end
            default: state <= ALU_STATE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses queued at accept, checked at rsp_valid.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int W   = 32;
   localparam int MUL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0;
   logic req0_ready, req1_ready;
   logic [W-1:0] req0_srcA = '0, req0_srcB = '0, req1_srcA = '0, req1_srcB = '0;
   logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
   logic [W-1:0] alu_srcA, alu_srcB, alu_out;
   logic [2:0] alu_ctrl;
   logic rsp_valid, rsp_id, rsp_err, busy;
   logic [W-1:0] rsp_result;

   typedef struct {
      bit           id;
      logic [W-1:0] res;
      bit           err;
      int           due;
   } exp_t;

   exp_t         sb[$];
   int           acc_port[$];
   int           acc_cyc[$];
   logic [W-1:0] pend_exp[2];
   int           cyc = 0;
   int           n_chk = 0;
   int           n_fail = 0;

   alu_arbiter #(.WORD_SIZE(W), .MUL_LATENCY(MUL)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_srcA(req0_srcA), .req0_srcB(req0_srcB), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_srcA(req1_srcA), .req1_srcB(req1_srcB), .req1_op(req1_op),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the external ALU.
   always_comb begin
      alu_out = '0;
      case (alu_ctrl)
         ADD_OP:  alu_out = alu_srcA + alu_srcB;
         SUB_OP:  alu_out = alu_srcA - alu_srcB;
         MUL_OP:  alu_out = alu_srcA * alu_srcB;
         AND_OP:  alu_out = alu_srcA & alu_srcB;
         OR_OP:   alu_out = alu_srcA | alu_srcB;
         default: alu_out = '0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (req0_valid && req0_ready) begin
            sb.push_back('{1'b0, pend_exp[0], req0_op > 3'd4, cyc + ((req0_op == 3'd2) ? MUL : 1) + 1});
            acc_port.push_back(0);
            acc_cyc.push_back(cyc);
         end
         if (req1_valid && req1_ready) begin
            sb.push_back('{1'b1, pend_exp[1], req1_op > 3'd4, cyc + ((req1_op == 3'd2) ? MUL : 1) + 1});
            acc_port.push_back(1);
            acc_cyc.push_back(cyc);
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("rsp_result", rsp_result, e.res);
               check_eq("rsp_id", rsp_id, e.id);
               check_eq("rsp_err", rsp_err, e.err);
               check_eq("rsp_latency", cyc, e.due);
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the op.
   task automatic send(input int port, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp);
      bit got;
      got = 1'b0;
      pend_exp[port] = exp;
      if (port == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_srcA = a; req0_srcB = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_srcA = a; req1_srcB = b;
      end
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = (port == 0) ? req0_ready : req1_ready;
      end
      if (!got) check_eq("accept_timeout", got, 1'b1);
      @(posedge clk); #1;
      if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check_eq({tag, "_rsp_id"}, rsp_id, 1'b0);
      check_eq({tag, "_rsp_result"}, rsp_result, '0);
      check_eq({tag, "_rsp_err"}, rsp_err, 1'b0);
      check_eq({tag, "_alu"}, {alu_srcA, alu_srcB}, '0);
      check_eq({tag, "_alu_ctrl"}, alu_ctrl, 3'(ADD_OP));
      check_eq({tag, "_ready"}, {req1_ready, req0_ready}, 2'b00);
   endtask

   initial begin
      logic [W-1:0] sa, sb_v;
      logic [2:0]   sc;

      #12;
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: ADD on port 0, busy for exactly one cycle
      send(0, ADD_OP, 32'd5, 32'd7, 32'd12);
      check_eq("add_busy_t1", busy, 1'b1);
      @(posedge clk); #1;
      check_eq("add_busy_t2", busy, 1'b0);
      check_eq("add_rsp_valid_t2", rsp_valid, 1'b1);

      // 2: SUB on port 1 wraps
      send(1, SUB_OP, 32'd3, 32'd5, 32'hFFFF_FFFE);
      @(posedge clk); #1;

      // 3: MUL holds ALU inputs; a port-1 request waits out the occupancy
      send(0, MUL_OP, 32'd6, 32'd7, 32'd42);
      sa = alu_srcA; sb_v = alu_srcB; sc = alu_ctrl;
      check_eq("mul_alu_ops", {sa, sb_v}, {32'd6, 32'd7});
      check_eq("mul_alu_ctrl", sc, 3'(MUL_OP));
      fork
         send(1, OR_OP, 32'hF0, 32'h0F, 32'hFF);
         begin
            for (int i = 0; i < MUL; i++) begin
               @(negedge clk);
               check_eq("mul_ready_low", {req1_ready, req0_ready}, 2'b00);
               check_eq("mul_busy", busy, 1'b1);
               check_eq("mul_alu_stable", {alu_srcA, alu_srcB, alu_ctrl}, {sa, sb_v, sc});
            end
         end
      join
      repeat (3) @(posedge clk); #1;

      // 4: both ports always valid -> strict alternation, one accept per 2 cycles
      acc_port.delete(); acc_cyc.delete();
      fork
         for (int i = 0; i < 4; i++) send(0, ADD_OP, 32'(i), 32'd100, 32'(i + 100));
         for (int i = 0; i < 4; i++) send(1, AND_OP, 32'(i + 8), 32'hC, 32'((i + 8) & 12));
      join
      check_eq("rr_count", acc_port.size(), 8);
      for (int i = 0; i < acc_port.size(); i++) begin
         check_eq("rr_order", acc_port[i], i % 2);
         if (i > 0) check_eq("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
      end
      repeat (3) @(posedge clk); #1;

      // 5: undefined op flags an error; the next op clears it
      send(0, 3'b111, 32'd9, 32'd9, 32'd0);
      @(posedge clk); #1;
      check_eq("undef_err", rsp_err, 1'b1);
      send(1, OR_OP, 32'h1, 32'h2, 32'h3);
      @(posedge clk); #1;
      check_eq("undef_err_cleared", rsp_err, 1'b0);

      // 6: reset mid-MUL abandons the op
      send(0, MUL_OP, 32'd3, 32'd3, 32'd9);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check_idle_outputs("midreset");
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check_eq("no_rsp_after_reset", rsp_valid, 1'b0);
      end
      @(posedge clk); #1;
      send(1, AND_OP, 32'hF0, 32'h3C, 32'h30);
      repeat (4) @(posedge clk); #1;

      check_eq("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage ALU between two requesters with round-robin arbitration. Registers the granted operands, holds them on the ALU inputs for the op's occupancy: one cycle, or `MUL_LATENCY` cycles for `MUL_OP`, so the multiplier runs as a multicycle path. Captures the ALU result and returns it on a tagged response bus. Sits between the pipeline's execute-stage issue logic (and a secondary requester) and the ALU.

## Interface
- `WORD_SIZE`, 32, operand/result width (same value as `constants.v`)
- `MUL_LATENCY`, 4, ALU occupancy in cycles for `MUL_OP`; legal range 1..15

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  request pending on port 0 / 1
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle
- `req0_srcA`, `req0_srcB` / `req1_*`  in  WORD_SIZE  operands
- `req0_op` / `req1_op`  in  3  ALU control code (`ADD_OP`, `SUB_OP`, `MUL_OP`, `AND_OP`, `OR_OP`)
- `alu_srcA`, `alu_srcB`  out  WORD_SIZE  to ALU
- `alu_ctrl`  out  3  to ALU
- `alu_out`  in  WORD_SIZE  from ALU
- `rsp_valid`  out  1  one-cycle pulse, result available
- `rsp_id`  out  1  port that issued the completed op
- `rsp_result`  out  WORD_SIZE  captured ALU result
- `rsp_err`  out  1  op code was not one of the five defined
- `busy`  out  1  state is EXEC

## Operation
**States**
- IDLE: arbitrate and accept one request.
- EXEC: drive the ALU from the operand registers; `cnt` counts down.

**Arbitration in IDLE**
- If only one port is valid, that port wins.
- If both are valid, the port named by `rr_ptr` wins.
- `reqN_ready` = (state==IDLE) && winner==N. Ready depends on valid; valid must never depend on ready.
- Requesters hold valid and data stable until accepted.

**On accept (valid && ready)**
- Latch srcA, srcB, op and id.
- `rr_ptr` <= other port.
- `cnt` <= (op==`MUL_OP`) ? MUL_LATENCY-1 : 0.
- State -> EXEC.

**In EXEC**
- `alu_srcA`/`alu_srcB`/`alu_ctrl` = latched values.
- If `cnt`!=0: decrement.
- If `cnt`==0: capture `alu_out` into `rsp_result`, set `rsp_err` for an undefined op (ALU yields 0), pulse `rsp_valid` next cycle with `rsp_id`, state -> IDLE.

**Outside EXEC**
- ALU inputs = 0 and `alu_ctrl` = `ADD_OP`.

**Width rules**
- Results wrap modulo 2^WORD_SIZE (SUB borrow and MUL upper half discarded); the block does no arithmetic itself.

**Reset**
- Values: state IDLE, `rr_ptr` 0, `cnt` 0, `busy` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_result` 0, `rsp_err` 0, `req*_ready` 0 until the first IDLE cycle with valid.
- Reset mid-EXEC abandons the op; no response is ever produced for it.

## Timing
- Accept in cycle T. EXEC spans T+1..T+L, where L=1 for non-MUL and L=MUL_LATENCY for MUL.
- `rsp_valid` is high in cycle T+L+1, the same cycle the block is back in IDLE. A new accept can occur in that cycle, giving a throughput of one op per L+1 cycles.
- `rsp_*` fields hold their value until the next completion; only `rsp_valid` pulses.
- Both valid in the same cycle: only the `rr_ptr` winner is accepted. The loser stays pending and wins at the next IDLE.
- Valid arriving during EXEC gets ready=0 and is served at the next IDLE.

## Structure
- Op codes and `WORD_SIZE` stay in `constants.v`. Add there `ALU_STATE_IDLE`/`ALU_STATE_EXEC` encodings and `MUL_LATENCY_DEFAULT`.
- One natural sub-module: `rr_arb2`, a two-requester round-robin grant with pointer update on accept.
- Instantiate the existing ALU externally (the block only drives its inputs), so the pair composes in the execute stage.

## Test plan
1. Port 0: ADD 5, 7 at T → `rsp_valid` at T+2, `rsp_result`=12, `rsp_id`=0, `rsp_err`=0; `busy` high at T+1 only.
2. Port 1: SUB 3, 5 → `rsp_result`=0xFFFFFFFE at T+2.
3. Port 0: MUL 6, 7 with MUL_LATENCY=4 → `req*_ready` low T+1..T+4, `alu_*` stable throughout, `rsp_result`=42 at T+5.
4. Both ports continuously valid from reset, 8 ops → grants alternate 0,1,0,1,…; `rsp_id` sequence matches; accepts every 2 cycles.
5. Op 3'b111 (undefined) → `rsp_result`=0, `rsp_err`=1, latency 2; next valid op clears `rsp_err`.
6. `rst_n` low at T+2 during MUL → no `rsp_valid` ever for that op; all outputs at reset values; after release, a port-1 AND 0xF0, 0x3C gives 0x30 with `rsp_id`=1.
